// File: rtl/rega_controller.sv
// Irrigation sequencer placed in front of the BCD countdown timer.
// It latches a watering duration from the switches and loads it into the timer presets.
// While watering it gates the valve and produces the 1 Hz count tick. After each cycle it
// holds the valve off for a cooldown period. A free-running digit selector drives the
// display scan.
//
// Ports:
//   clk, reset             system clock; asynchronous active-high reset
//   start, stop, umido     watering request, abort request, soil-wet sensor (1 = wet)
//   dur_dm, dur_um         requested duration, BCD tens / units of minutes
//   timer_zero             timer reports 00:00
//   tick, load             one-cycle count pulse and preset load strobe to the timer
//   preset_us/ds/um/dm     latched BCD preset digits
//   seletor                display digit select (0..3)
//   valvula                valve drive
//   abortado               last cycle ended by stop or wet soil
//   estado                 FSM state code (IDLE=00, LOAD=01, WATER=10, COOLDOWN=11)
module rega_controller #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned COOLDOWN_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       umido,
  input  logic [3:0] dur_dm,
  input  logic [3:0] dur_um,
  input  logic       timer_zero,
  output logic       tick,
  output logic       load,
  output logic [3:0] preset_us,
  output logic [3:0] preset_ds,
  output logic [3:0] preset_um,
  output logic [3:0] preset_dm,
  output logic [1:0] seletor,
  output logic       valvula,
  output logic       abortado,
  output logic [1:0] estado
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SecW  = (COOLDOWN_S > 1) ? $clog2(COOLDOWN_S) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PreW-1:0]  PreLast  = PreW'(TICK_DIV - 1);
  localparam logic [SecW-1:0]  SecLast  = SecW'(COOLDOWN_S - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StLoad     = 2'b01,
    StWater    = 2'b10,
    StCooldown = 2'b11
  } stateE;

  stateE            stateQ, stateD;
  logic [PreW-1:0]  preQ, preD;
  logic [SecW-1:0]  secQ, secD;
  logic [ScanW-1:0] scanQ;
  logic [1:0]       seletorQ;
  logic             tickQ, tickD;
  logic             loadQ, valvQ;
  logic             abortQ, abortD;
  logic             latchPreset;
  logic [3:0]       presetDmQ, presetUmQ, presetDsQ, presetUsQ;
  logic             startOk;
  logic             preWrap;

  assign startOk = start && !stop && !umido && (dur_dm <= 4'd9) && (dur_um <= 4'd9) &&
                   ({dur_dm, dur_um} != 8'h00);
  assign preWrap = (preQ == PreLast);

  always_comb begin
    stateD      = stateQ;
    preD        = preQ;
    secD        = secQ;
    tickD       = 1'b0;
    abortD      = abortQ;
    latchPreset = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (startOk) begin
          stateD      = StLoad;
          latchPreset = 1'b1;
          abortD      = 1'b0;
          preD        = '0;
          secD        = '0;
        end
      end
      StLoad: begin
        stateD = StWater;
        preD   = '0;
      end
      StWater: begin
        // Abort outranks normal completion; neither exit emits a tick.
        if (stop || umido) begin
          stateD = StCooldown;
          abortD = 1'b1;
          preD   = '0;
          secD   = '0;
        end else if (timer_zero) begin
          stateD = StCooldown;
          preD   = '0;
          secD   = '0;
        end else begin
          tickD = preWrap;
          preD  = preWrap ? '0 : preQ + PreW'(1);
        end
      end
      StCooldown: begin
        if (preWrap) begin
          preD = '0;
          if (secQ == SecLast) begin
            stateD = StIdle;
            secD   = '0;
          end else begin
            secD = secQ + SecW'(1);
          end
        end else begin
          preD = preQ + PreW'(1);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
      preQ   <= '0;
      secQ   <= '0;
      tickQ  <= 1'b0;
      loadQ  <= 1'b0;
      valvQ  <= 1'b0;
      abortQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      preQ   <= preD;
      secQ   <= secD;
      tickQ  <= tickD;
      // Registered decodes of the next state, so they line up with estado.
      loadQ  <= (stateD == StLoad);
      valvQ  <= (stateD == StWater);
      abortQ <= abortD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presetDmQ <= '0;
      presetUmQ <= '0;
      presetDsQ <= '0;
      presetUsQ <= '0;
    end else if (latchPreset) begin
      presetDmQ <= dur_dm;
      presetUmQ <= dur_um;
      presetDsQ <= '0;
      presetUsQ <= '0;
    end
  end

  // Display scan runs in every state and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanQ    <= '0;
      seletorQ <= '0;
    end else if (scanQ == ScanLast) begin
      scanQ    <= '0;
      seletorQ <= seletorQ + 2'd1;
    end else begin
      scanQ <= scanQ + ScanW'(1);
    end
  end

  assign estado    = stateQ;
  assign tick      = tickQ;
  assign load      = loadQ;
  assign valvula   = valvQ;
  assign abortado  = abortQ;
  assign seletor   = seletorQ;
  assign preset_dm = presetDmQ;
  assign preset_um = presetUmQ;
  assign preset_ds = presetDsQ;
  assign preset_us = presetUsQ;

endmodule

// File: tb/tb_rega_controller.sv
// Self-checking bench for rega_controller with TICK_DIV=4, SCAN_DIV=2, COOLDOWN_S=2.
// A cycle-count reference model predicts estado/load/valvula/tick/abortado/seletor.
module tb_rega_controller;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int CS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, umido = 1'b0, timer_zero = 1'b0;
  logic [3:0] dur_dm = 4'd0, dur_um = 4'd0;
  logic       tick, load, valvula, abortado;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic [1:0] seletor, estado;

  int tests = 0;
  int failed = 0;

  rega_controller #(.TICK_DIV(TD), .SCAN_DIV(SD), .COOLDOWN_S(CS)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .umido(umido),
    .dur_dm(dur_dm), .dur_um(dur_um), .timer_zero(timer_zero),
    .tick(tick), .load(load),
    .preset_us(preset_us), .preset_ds(preset_ds), .preset_um(preset_um),
    .preset_dm(preset_dm), .seletor(seletor), .valvula(valvula),
    .abortado(abortado), .estado(estado)
  );

  always #5 clk = ~clk;

  wire [7:0] obsVec = {estado, load, valvula, tick, abortado, seletor};

  // Reference model: which phase we are in, cycles spent in it, cycles since reset.
  logic [1:0] mState = 2'd0;
  int         mCnt = 0;
  int         mScan = 0;
  logic       mAbort = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState <= 2'd0; mCnt <= 0; mAbort <= 1'b0; mScan <= 0;
    end else begin
      mScan <= mScan + 1;
      case (mState)
        2'd0: if (start && !stop && !umido && dur_dm <= 9 && dur_um <= 9 &&
                  (dur_dm != 0 || dur_um != 0)) begin
          mState <= 2'd1; mAbort <= 1'b0; mCnt <= 0;
        end
        2'd1: begin mState <= 2'd2; mCnt <= 0; end
        2'd2: begin
          if (stop || umido) begin mState <= 2'd3; mAbort <= 1'b1; mCnt <= 0; end
          else if (timer_zero) begin mState <= 2'd3; mCnt <= 0; end
          else mCnt <= mCnt + 1;
        end
        default: begin
          if (mCnt + 1 >= CS * TD) begin mState <= 2'd0; mCnt <= 0; end
          else mCnt <= mCnt + 1;
        end
      endcase
    end
  end

  function automatic logic [7:0] expVec();
    logic t;
    t = (mState == 2'd2) && (mCnt > 0) && (mCnt % TD == 0);
    return {mState, mState == 2'd1, mState == 2'd2, t, mAbort, 2'((mScan / SD) % 4)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (obsVec !== 8'h00) begin
      failed++; $display("FAIL reset_outputs: got %b want 00000000", obsVec);
    end
    tests++;
    if ({preset_dm, preset_um, preset_ds, preset_us} !== 16'h0000) begin
      failed++;
      $display("FAIL reset_presets: got %h want 0000",
               {preset_dm, preset_um, preset_ds, preset_us});
    end
    reset = 1'b0;
  endtask

  task automatic test_normal(input logic [3:0] dm, input logic [3:0] um, input int waterLen);
    dur_dm = dm; dur_um = um; start = 1'b1;
    for (int i = 0; i < waterLen + 12; i++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec()) begin
        failed++; $display("FAIL normal cyc %0d: got %b want %b", i, obsVec, expVec());
      end
      if (i == 0) begin
        tests++;
        if ({preset_dm, preset_um, preset_ds, preset_us} !== {dm, um, 8'h00}) begin
          failed++;
          $display("FAIL normal_presets: got %h want %h",
                   {preset_dm, preset_um, preset_ds, preset_us}, {dm, um, 8'h00});
        end
        start = 1'b0;
      end
      if (i == waterLen + 1) begin
        tests++;
        if ({valvula, abortado, estado} !== 4'b0011) begin
          failed++; $display("FAIL normal_exit: got %b want 0011", {valvula, abortado, estado});
        end
      end
      if (i == waterLen + 9) begin
        tests++;
        if (estado !== 2'b00) begin
          failed++; $display("FAIL normal_idle: got %b want 00", estado);
        end
      end
      timer_zero = (i == waterLen);
    end
  endtask

  task automatic test_abort(input int waterLen, input bit useStop);
    dur_dm = 4'($urandom_range(0, 9)); dur_um = 4'($urandom_range(1, 9)); start = 1'b1;
    for (int i = 0; i < waterLen + 12; i++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec()) begin
        failed++; $display("FAIL abort cyc %0d: got %b want %b", i, obsVec, expVec());
      end
      if (i == waterLen + 1) begin
        tests++;
        if ({valvula, tick, abortado, estado} !== 5'b00111) begin
          failed++;
          $display("FAIL abort_exit: got %b want 00111", {valvula, tick, abortado, estado});
        end
      end
      if (i == 0) start = 1'b0;
      if (i == waterLen) begin
        if (useStop) stop = 1'b1; else umido = 1'b1;
      end
      if (i == waterLen + 3) begin stop = 1'b0; umido = 1'b0; end
    end
  endtask

  task automatic test_reject();
    logic [3:0] dms [6] = '{4'd0, 4'd0, 4'd3, 4'hA, 4'd2, 4'hF};
    logic [3:0] ums [6] = '{4'd0, 4'hA, 4'd5, 4'd2, 4'd5, 4'hC};
    logic       wet [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       stp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      dur_dm = dms[c]; dur_um = ums[c]; umido = wet[c]; stop = stp[c]; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        tests++;
        if ({estado, load} !== 3'b000 || obsVec !== expVec()) begin
          failed++;
          $display("FAIL reject case %0d cyc %0d: got %b want %b", c, i, obsVec, expVec());
        end
      end
    end
    start = 1'b0; stop = 1'b0; umido = 1'b0;
  endtask

  task automatic test_lockout(input int waterLen);
    dur_dm = 4'd1; dur_um = 4'($urandom_range(0, 9)); start = 1'b1;
    for (int i = 0; i < waterLen + 22; i++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec()) begin
        failed++; $display("FAIL lockout cyc %0d: got %b want %b", i, obsVec, expVec());
      end
      if (i > waterLen && i < waterLen + 9) begin
        tests++;
        if (load !== 1'b0) begin
          failed++; $display("FAIL lockout_noload cyc %0d: got %b want 0", i, load);
        end
      end
      if (i == waterLen + 9) begin
        tests++;
        if (estado !== 2'b00) begin
          failed++; $display("FAIL lockout_idle: got %b want 00", estado);
        end
      end
      if (i == waterLen + 10) begin
        tests++;
        if ({estado, load} !== 3'b011) begin
          failed++; $display("FAIL lockout_reload: got %b want 011", {estado, load});
        end
        start = 1'b0;
      end
      timer_zero = (i == waterLen);
      stop = (i == waterLen + 11);
    end
  endtask

  task automatic test_scan();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    dur_dm = 4'd0; dur_um = 4'd1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      tests++;
      if (seletor !== 2'((i / SD) % 4) || obsVec !== expVec()) begin
        failed++;
        $display("FAIL scan cyc %0d: got sel %0d want %0d (vec %b want %b)", i, seletor,
                 (i / SD) % 4, obsVec, expVec());
      end
      start = (i == 1);
    end
    @(negedge clk);
    tests++;
    if (valvula !== 1'b1 || seletor === 2'd0) begin
      failed++; $display("FAIL prereset_water: got valv %b sel %0d want 1 nonzero", valvula,
                         seletor);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({valvula, tick, seletor, estado, abortado, load, preset_dm, preset_um} !== 16'h0) begin
      failed++;
      $display("FAIL async_reset: got %h want 0000",
               {valvula, tick, seletor, estado, abortado, load, preset_dm, preset_um});
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    tests++;
    if (obsVec !== expVec()) begin
      failed++; $display("FAIL post_reset: got %b want %b", obsVec, expVec());
    end
  endtask

  initial begin
    logic [3:0] dm, um;
    test_reset();
    test_normal(4'd0, 4'd1, 9);
    for (int k = 0; k < 3; k++) begin
      dm = 4'($urandom_range(0, 9));
      um = 4'($urandom_range(0, 9));
      if (dm == 0 && um == 0) um = 4'd1;
      test_normal(dm, um, $urandom_range(1, 14));
    end
    for (int k = 0; k < 4; k++) test_abort($urandom_range(1, 12), k[0]);
    test_reject();
    test_lockout($urandom_range(2, 10));
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
